iir_resp_meter: RTL

IIR_RESP_METER -- requirements
Module: iir_resp_meter

---
 rtl/iir_pkg.sv | 24 ++
 rtl/iir_sat.sv | 22 ++
 rtl/iir_resp_meter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/iir_pkg.sv
// Shared widths, saturation limits and sample/power types for the IIR response meter.
package iir_pkg;

  localparam int IN_W  = 25;
  localparam int OUT_W = 18;
  localparam int PWR_W = 36;

  localparam logic signed [OUT_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 18'sh20000;

  typedef logic signed [IN_W-1:0]  in_sample_t;
  typedef logic signed [OUT_W-1:0] sample_t;
  typedef logic        [PWR_W-1:0] power_t;

  // Each square is at most 2^34, so the unsigned sum always fits in 36 bits.
  function automatic power_t power_of(input sample_t re, input sample_t im);
    logic signed [PWR_W-1:0] rr;
    logic signed [PWR_W-1:0] ii;
    rr = re * re;
    ii = im * im;
    return power_t'(rr) + power_t'(ii);
  endfunction

endpackage

// File: rtl/iir_sat.sv
// Single-component saturator: signed 3.22 in, signed 1.17 out, plus a clamp flag.
module iir_sat
  import iir_pkg::*;
(
  input  in_sample_t sample,
  output sample_t    sat_sample,
  output logic       clamp
);

  // The value fits in 1.17 only when the two integer bits just repeat the sign.
  always_comb begin
    clamp = !((sample[IN_W-1:IN_W-3] == 3'b000) || (sample[IN_W-1:IN_W-3] == 3'b111));
    if (!clamp) begin
      sat_sample = sample[IN_W-3:IN_W-3-OUT_W+1];
    end else if (sample[IN_W-1]) begin
      sat_sample = SAT_MIN;
    end else begin
      sat_sample = SAT_MAX;
    end
  end

endmodule

// File: rtl/iir_resp_meter.sv
// Saturates complex filter returns and reports the per-window peak power and its index.
// Optional saturation counter output is enabled by defining IIR_SAT_COUNT_EN.
module iir_resp_meter
  import iir_pkg::*;
#(
  parameter int WIN_LOG2 = 10
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                in_valid,
  input  logic [IN_W-1:0]     in_real,
  input  logic [IN_W-1:0]     in_imag,
  output logic                dout_valid,
  output logic [OUT_W-1:0]    dout_real,
  output logic [OUT_W-1:0]    dout_imag,
  output logic                win_valid,
  output logic [PWR_W-1:0]    win_peak,
  output logic [WIN_LOG2-1:0] win_peak_idx
`ifdef IIR_SAT_COUNT_EN
  ,
  output logic [WIN_LOG2:0]   win_sat_count
`endif
);

  // Valid semantics: in_valid is a one-cycle strobe with no backpressure; each
  // strobe is one sample and the pipeline accepts one on every cycle.
  sample_t sat_re;
  sample_t sat_im;
  logic    clamp_re;
  logic    clamp_im;

  iir_sat u_sat_re (.sample(in_real), .sat_sample(sat_re), .clamp(clamp_re));
  iir_sat u_sat_im (.sample(in_imag), .sat_sample(sat_im), .clamp(clamp_im));

  logic                pwr_valid;
  power_t              pwr;
  logic [WIN_LOG2-1:0] win_cnt;
  power_t              run_peak;
  logic [WIN_LOG2-1:0] run_idx;
  logic                peak_upd;
  power_t              next_peak;
  logic [WIN_LOG2-1:0] next_idx;
  logic                last;

  // Strictly-greater compare keeps the earliest index on ties.
  always_comb begin
    peak_upd  = pwr > run_peak;
    next_peak = peak_upd ? pwr : run_peak;
    next_idx  = peak_upd ? win_cnt : run_idx;
    last      = (win_cnt == {WIN_LOG2{1'b1}});
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_valid   <= 1'b0;
      dout_real    <= '0;
      dout_imag    <= '0;
      pwr_valid    <= 1'b0;
      pwr          <= '0;
      win_cnt      <= '0;
      run_peak     <= '0;
      run_idx      <= '0;
      win_valid    <= 1'b0;
      win_peak     <= '0;
      win_peak_idx <= '0;
    end else begin
      dout_valid <= in_valid;
      if (in_valid) begin
        dout_real <= sat_re;
        dout_imag <= sat_im;
      end
      pwr_valid <= dout_valid;
      if (dout_valid) begin
        pwr <= power_of(dout_real, dout_imag);
      end
      win_valid <= 1'b0;
      if (pwr_valid) begin
        win_cnt <= win_cnt + 1'b1;
        if (last) begin
          // Publish the finished window and clear so the next sample always loads.
          win_valid    <= 1'b1;
          win_peak     <= next_peak;
          win_peak_idx <= next_idx;
          run_peak     <= '0;
          run_idx      <= '0;
        end else begin
          run_peak <= next_peak;
          run_idx  <= next_idx;
        end
      end
    end
  end

`ifdef IIR_SAT_COUNT_EN
  logic                s1_clamp;
  logic                pwr_clamp;
  logic [WIN_LOG2:0]   sat_run;

  // Clamp flag rides alongside the sample so it is counted in the same window.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_clamp      <= 1'b0;
      pwr_clamp     <= 1'b0;
      sat_run       <= '0;
      win_sat_count <= '0;
    end else begin
      if (in_valid) begin
        s1_clamp <= clamp_re | clamp_im;
      end
      if (dout_valid) begin
        pwr_clamp <= s1_clamp;
      end
      if (pwr_valid) begin
        if (last) begin
          win_sat_count <= sat_run + (WIN_LOG2+1)'(pwr_clamp);
          sat_run       <= '0;
        end else begin
          sat_run <= sat_run + (WIN_LOG2+1)'(pwr_clamp);
        end
      end
    end
  end
`else
  logic unused_clamp;
  assign unused_clamp = clamp_re ^ clamp_im;
`endif

endmodule
